// File: rtl/wb_stage_pkg.sv
// Shared writeback definitions: source-select encoding (common with decode)
// and the load-hold FSM state encoding.
package wb_stage_pkg;

  typedef logic [1:0] wb_sel_t;

  localparam wb_sel_t WB_SEL_ALU = 2'b00;
  localparam wb_sel_t WB_SEL_MEM = 2'b01;
  localparam wb_sel_t WB_SEL_PC4 = 2'b10;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

endpackage

// File: rtl/wb_stage_retire_counter.sv
// Free-running retired-instruction counter; wraps modulo 2^CNT_WIDTH.
module wb_retire_counter #(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  // Advance by one on every committing edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, writeback source mux, register
// file write port, forwarding path and retire counter. Load data comes in
// unregistered from the data memory, so a hold register keeps it across stalls.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32,
  parameter int REG_SEL   = $clog2(NUM_REGS),
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [WORD_SIZE-1:0] result_in,
  input  logic [WORD_SIZE-1:0] pc_plus4_in,
  input  logic [REG_SEL-1:0]   rd_in,
  input  logic                 reg_write_in,
  input  logic [1:0]           wb_sel_in,
  input  logic [WORD_SIZE-1:0] read_data_in,
  output logic                 rf_we,
  output logic [REG_SEL-1:0]   rf_waddr,
  output logic [WORD_SIZE-1:0] rf_wdata,
  output logic                 fwd_valid,
  output logic [REG_SEL-1:0]   fwd_rd,
  output logic [WORD_SIZE-1:0] fwd_data,
  output logic [CNT_WIDTH-1:0] retire_count
);

  logic                        vld_p0;
  logic [REG_SEL-1:0]          rd_p0;
  logic                        reg_write_p0;
  wb_sel_t                     wb_sel_p0;
  logic signed [WORD_SIZE-1:0] result_p0;
  logic signed [WORD_SIZE-1:0] pc_plus4_p0;

  logic [0:0]                  state;
  logic signed [WORD_SIZE-1:0] ld_hold;
  logic signed [WORD_SIZE-1:0] ld_data;
  logic signed [WORD_SIZE-1:0] wb_data;
  logic                        writes;
  logic                        commit;

  // Writeback source select; the reserved code falls back to the ALU result.
  function automatic logic signed [WORD_SIZE-1:0] wb_mux(
    input wb_sel_t                     sel,
    input logic signed [WORD_SIZE-1:0] alu,
    input logic signed [WORD_SIZE-1:0] ld,
    input logic signed [WORD_SIZE-1:0] pc4
  );
    case (sel)
      WB_SEL_ALU: wb_mux = alu;
      WB_SEL_MEM: wb_mux = ld;
      WB_SEL_PC4: wb_mux = pc4;
      default:    wb_mux = alu;
    endcase
  endfunction

  // ---- MEM -> WB boundary (p0) ----
  // MEM/WB register: stall holds everything, flush turns the slot into a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0       <= 1'b0;
      rd_p0        <= '0;
      reg_write_p0 <= 1'b0;
      wb_sel_p0    <= WB_SEL_ALU;
      result_p0    <= '0;
      pc_plus4_p0  <= '0;
    end else if (!stall) begin
      vld_p0       <= in_valid && !flush;
      rd_p0        <= rd_in;
      reg_write_p0 <= reg_write_in;
      wb_sel_p0    <= wb_sel_in;
      result_p0    <= $signed(result_in);
      pc_plus4_p0  <= $signed(pc_plus4_in);
    end
  end

  // Hold FSM: capture the memory's load data on the first stalled edge, since
  // the memory output is not guaranteed stable while the load sits in WB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_RUN;
      ld_hold <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (stall && vld_p0 && (wb_sel_p0 == WB_SEL_MEM)) begin
            state   <= ST_HOLD;
            ld_hold <= $signed(read_data_in);
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  assign ld_data = (state == ST_HOLD) ? ld_hold : $signed(read_data_in);
  assign wb_data = wb_mux(wb_sel_p0, result_p0, ld_data, pc_plus4_p0);

  // x0 is hard-wired to zero, so it never writes nor forwards.
  assign writes = vld_p0 && reg_write_p0 && (rd_p0 != '0);
  assign commit = vld_p0 && !stall;

  assign rf_we     = writes && !stall;
  assign rf_waddr  = rd_p0;
  assign rf_wdata  = wb_data;
  // Forwarding stays live during a stall so a stalled consumer sees the value.
  assign fwd_valid = writes;
  assign fwd_rd    = rd_p0;
  assign fwd_data  = wb_data;

  wb_retire_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_retire (
    .clk  (clk),
    .rst  (rst),
    .inc  (commit),
    .count(retire_count)
  );

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a vector table for single-instruction
// writeback cases plus hand-written stall, flush, reset and wrap sequences.
// A second instance with a 4-bit counter runs in parallel for the wrap case.
module tb_wb_stage;
  import wb_stage_pkg::*;

  localparam int W  = 32;
  localparam int RS = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          flush;
  logic          in_valid;
  logic [W-1:0]  result_in;
  logic [W-1:0]  pc_plus4_in;
  logic [RS-1:0] rd_in;
  logic          reg_write_in;
  logic [1:0]    wb_sel_in;
  logic [W-1:0]  read_data_in;

  logic          rf_we, fwd_valid;
  logic [RS-1:0] rf_waddr, fwd_rd;
  logic [W-1:0]  rf_wdata, fwd_data;
  logic [63:0]   retire_count;

  logic          s_rf_we, s_fwd_valid;
  logic [RS-1:0] s_rf_waddr, s_fwd_rd;
  logic [W-1:0]  s_rf_wdata, s_fwd_data;
  logic [3:0]    s_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_cnt;

  always #5 clk = ~clk;

  wb_stage #(.WORD_SIZE(W), .NUM_REGS(32), .CNT_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .result_in(result_in), .pc_plus4_in(pc_plus4_in), .rd_in(rd_in),
    .reg_write_in(reg_write_in), .wb_sel_in(wb_sel_in), .read_data_in(read_data_in),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .retire_count(retire_count)
  );

  wb_stage #(.WORD_SIZE(W), .NUM_REGS(32), .CNT_WIDTH(4)) dut_small (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .result_in(result_in), .pc_plus4_in(pc_plus4_in), .rd_in(rd_in),
    .reg_write_in(reg_write_in), .wb_sel_in(wb_sel_in), .read_data_in(read_data_in),
    .rf_we(s_rf_we), .rf_waddr(s_rf_waddr), .rf_wdata(s_rf_wdata),
    .fwd_valid(s_fwd_valid), .fwd_rd(s_fwd_rd), .fwd_data(s_fwd_data),
    .retire_count(s_cnt)
  );

  typedef struct packed {
    logic          vld;
    logic          rw;
    logic [1:0]    sel;
    logic [RS-1:0] rd;
    logic [W-1:0]  res;
    logic [W-1:0]  pc4;
    logic [W-1:0]  rdata;
    logic          exp_we;
    logic          exp_fwd;
    logic [W-1:0]  exp_wdata;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] sel,
                       input logic [RS-1:0] rd, input logic [W-1:0] res,
                       input logic [W-1:0] pc4);
    in_valid     = v;
    reg_write_in = rw;
    wb_sel_in    = sel;
    rd_in        = rd;
    result_in    = res;
    pc_plus4_in  = pc4;
  endtask

  initial begin
    //           vld  rw  sel    rd     result        pc4           rdata         we   fwd  wdata
    vecs[0] = '{1'b1,1'b1,2'b00,5'd5, 32'h0000_1234,32'h0000_0000,32'h0000_0000,1'b1,1'b1,32'h0000_1234};
    vecs[1] = '{1'b1,1'b1,2'b01,5'd7, 32'h0000_0040,32'h0000_0000,32'hFFFF_FF80,1'b1,1'b1,32'hFFFF_FF80};
    vecs[2] = '{1'b1,1'b1,2'b10,5'd1, 32'h0000_0008,32'h0000_0104,32'h0000_0000,1'b1,1'b1,32'h0000_0104};
    vecs[3] = '{1'b1,1'b1,2'b10,5'd0, 32'h0000_0008,32'h0000_0104,32'h0000_0000,1'b0,1'b0,32'h0000_0104};
    vecs[4] = '{1'b1,1'b1,2'b11,5'd3, 32'hDEAD_BEEF,32'h0000_0055,32'h0000_0077,1'b1,1'b1,32'hDEAD_BEEF};
    vecs[5] = '{1'b1,1'b0,2'b00,5'd4, 32'h0000_0009,32'h0000_0000,32'h0000_0000,1'b0,1'b0,32'h0000_0009};
    vecs[6] = '{1'b0,1'b1,2'b00,5'd6, 32'h0000_0001,32'h0000_0000,32'h0000_0000,1'b0,1'b0,32'h0000_0001};

    rst = 1'b0; stall = 1'b0; flush = 1'b0; read_data_in = '0;
    drive(1'b0, 1'b0, 2'b00, '0, '0, '0);
    exp_cnt = '0;

    // Reset state.
    #12;
    check("rst_rf_we",     64'(rf_we),        64'd0);
    check("rst_rf_wdata",  64'(rf_wdata),     64'd0);
    check("rst_fwd_valid", 64'(fwd_valid),    64'd0);
    check("rst_count",     retire_count,      64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Single-instruction vectors: accept, then check the WB cycle.
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].vld, vecs[i].rw, vecs[i].sel, vecs[i].rd, vecs[i].res, vecs[i].pc4);
      tick();
      in_valid     = 1'b0;
      read_data_in = vecs[i].rdata;
      #1;
      check($sformatf("v%0d_rf_we", i),       64'(rf_we),       64'(vecs[i].exp_we));
      check($sformatf("v%0d_rf_waddr", i),    64'(rf_waddr),    64'(vecs[i].rd));
      check($sformatf("v%0d_rf_wdata", i),    64'(rf_wdata),    64'(vecs[i].exp_wdata));
      check($sformatf("v%0d_fwd_valid", i),   64'(fwd_valid),   64'(vecs[i].exp_fwd));
      check($sformatf("v%0d_fwd_rd", i),      64'(fwd_rd),      64'(vecs[i].rd));
      check($sformatf("v%0d_fwd_data", i),    64'(fwd_data),    64'(vecs[i].exp_wdata));
      check($sformatf("v%0d_count", i),       retire_count,     exp_cnt);
      check($sformatf("v%0d_s_rf_we", i),     64'(s_rf_we),     64'(vecs[i].exp_we));
      check($sformatf("v%0d_s_rf_waddr", i),  64'(s_rf_waddr),  64'(vecs[i].rd));
      check($sformatf("v%0d_s_rf_wdata", i),  64'(s_rf_wdata),  64'(vecs[i].exp_wdata));
      check($sformatf("v%0d_s_fwd_valid", i), 64'(s_fwd_valid), 64'(vecs[i].exp_fwd));
      check($sformatf("v%0d_s_fwd_rd", i),    64'(s_fwd_rd),    64'(vecs[i].rd));
      check($sformatf("v%0d_s_fwd_data", i),  64'(s_fwd_data),  64'(vecs[i].exp_wdata));
      check($sformatf("v%0d_s_count", i),     64'(s_cnt),       64'(exp_cnt[3:0]));
      if (vecs[i].vld) exp_cnt++;
    end
    tick();
    check("vec_final_count", retire_count, exp_cnt);

    // Load stalled three cycles while the memory output changes underneath.
    drive(1'b1, 1'b1, WB_SEL_MEM, 5'd8, 32'h5, 32'h0);
    read_data_in = '0;
    tick();
    in_valid = 1'b0;
    stall = 1'b1;
    read_data_in = 32'hAAAA_0001;
    #1;
    check("hold1_rf_we",     64'(rf_we),     64'd0);
    check("hold1_fwd_valid", 64'(fwd_valid), 64'd1);
    check("hold1_fwd_data",  64'(fwd_data),  64'hAAAA_0001);
    tick();
    read_data_in = '0;
    #1;
    check("hold2_rf_we",    64'(rf_we),    64'd0);
    check("hold2_fwd_data", 64'(fwd_data), 64'hAAAA_0001);
    check("hold2_fwd_rd",   64'(fwd_rd),   64'd8);
    tick();
    check("hold3_rf_we",    64'(rf_we),    64'd0);
    check("hold3_fwd_data", 64'(fwd_data), 64'hAAAA_0001);
    check("hold3_count",    retire_count,  exp_cnt);
    stall = 1'b0;
    #1;
    check("release_rf_we",    64'(rf_we),    64'd1);
    check("release_rf_wdata", 64'(rf_wdata), 64'hAAAA_0001);
    check("release_waddr",    64'(rf_waddr), 64'd8);
    exp_cnt++;
    tick();
    check("release_count", retire_count,     exp_cnt);
    check("release_state", 64'(dut.state),   64'(ST_RUN));

    // Flush turns the incoming instruction into a bubble.
    drive(1'b1, 1'b1, WB_SEL_ALU, 5'd9, 32'h99, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_rf_we",     64'(rf_we),     64'd0);
    check("flush_fwd_valid", 64'(fwd_valid), 64'd0);
    tick();
    check("flush_count",     retire_count,   exp_cnt);

    // Stall together with flush holds the WB contents.
    drive(1'b1, 1'b1, WB_SEL_ALU, 5'd10, 32'h10A, 32'h0);
    tick();
    stall = 1'b1;
    flush = 1'b1;
    drive(1'b1, 1'b1, WB_SEL_ALU, 5'd11, 32'hBAD, 32'h0);
    #1;
    check("sf1_rf_we",    64'(rf_we),    64'd0);
    check("sf1_fwd_rd",   64'(fwd_rd),   64'd10);
    check("sf1_fwd_data", 64'(fwd_data), 64'h10A);
    tick();
    check("sf2_fwd_valid", 64'(fwd_valid), 64'd1);
    check("sf2_fwd_rd",    64'(fwd_rd),    64'd10);
    check("sf2_fwd_data",  64'(fwd_data),  64'h10A);
    check("sf2_count",     retire_count,   exp_cnt);
    stall = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("sf_rel_rf_we",    64'(rf_we),    64'd1);
    check("sf_rel_waddr",    64'(rf_waddr), 64'd10);
    check("sf_rel_rf_wdata", 64'(rf_wdata), 64'h10A);
    exp_cnt++;
    tick();
    check("sf_rel_count", retire_count, exp_cnt);

    // Asynchronous reset while the load-hold FSM is in HOLD.
    drive(1'b1, 1'b1, WB_SEL_MEM, 5'd12, 32'h0, 32'h0);
    tick();
    in_valid = 1'b0;
    stall = 1'b1;
    read_data_in = 32'h1234_5678;
    tick();
    check("pre_rst_state", 64'(dut.state), 64'(ST_HOLD));
    #2;
    rst = 1'b0;
    #1;
    check("arst_rf_we",     64'(rf_we),       64'd0);
    check("arst_rf_waddr",  64'(rf_waddr),    64'd0);
    check("arst_rf_wdata",  64'(rf_wdata),    64'd0);
    check("arst_fwd_valid", 64'(fwd_valid),   64'd0);
    check("arst_fwd_rd",    64'(fwd_rd),      64'd0);
    check("arst_fwd_data",  64'(fwd_data),    64'd0);
    check("arst_count",     retire_count,     64'd0);
    check("arst_s_count",   64'(s_cnt),       64'd0);
    check("arst_state",     64'(dut.state),   64'(ST_RUN));
    @(negedge clk);
    rst = 1'b1;
    stall = 1'b0;
    exp_cnt = '0;

    // Seventeen back-to-back commits wrap the 4-bit counter to 1.
    for (int j = 1; j <= 17; j++) begin
      drive(1'b1, 1'b1, WB_SEL_ALU, 5'd2, 32'(j), 32'h0);
      tick();
      check($sformatf("wrap%0d_s_count", j), 64'(s_cnt),  64'(exp_cnt[3:0]));
      check($sformatf("wrap%0d_count", j),   retire_count, exp_cnt);
      exp_cnt++;
    end
    in_valid = 1'b0;
    tick();
    check("wrap_s_count_final", 64'(s_cnt),  64'd1);
    check("wrap_count_final",   retire_count, exp_cnt);

    // After reset the load path is back to the live memory data.
    drive(1'b1, 1'b1, WB_SEL_MEM, 5'd12, 32'h0, 32'h0);
    tick();
    in_valid = 1'b0;
    read_data_in = 32'h0BAD_F00D;
    #1;
    check("post_rst_ld_wdata", 64'(rf_wdata), 64'h0BAD_F00D);
    check("post_rst_ld_we",    64'(rf_we),    64'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage directly downstream of mem_stage. Holds the MEM/WB pipeline register and selects the register-file write data from three sources: ALU result, load data or link address.
- Drives the register-file write port and the forwarding path back to execute. Counts retired instructions.
- Load data arrives unregistered from the data memory, whose synchronous read is already one cycle latent. A small hold FSM keeps load data stable across stalls.

Parameters:
WORD_SIZE, 32, datapath width
NUM_REGS, 32, architectural register count
REG_SEL, $clog2(NUM_REGS), register index width
CNT_WIDTH, 64, retired-instruction counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
stall  in  1  hazard unit: hold the WB instruction, no commit
flush  in  1  hazard unit: insert a bubble instead of the incoming MEM instruction
in_valid  in  1  MEM-stage instruction valid
result_in  in  WORD_SIZE  ALU result (mem_stage result_out)
pc_plus4_in  in  WORD_SIZE  link address for jal/jalr
rd_in  in  REG_SEL  destination register (mem_stage rd_out)
reg_write_in  in  1  mem_stage reg_write_out
wb_sel_in  in  2  writeback source select
read_data_in  in  WORD_SIZE  d_mem b_dout, valid in the WB cycle, already sign/zero extended
rf_we  out  1  register-file write enable
rf_waddr  out  REG_SEL  register-file write address
rf_wdata  out  WORD_SIZE  register-file write data
fwd_valid  out  1  forwarding data valid (WB holds a writing instruction)
fwd_rd  out  REG_SEL  forwarding destination
fwd_data  out  WORD_SIZE  forwarding value, equal to the rf_wdata mux output
retire_count  out  CNT_WIDTH  committed-instruction count

Behaviour:
- Reset (rst=0, asynchronous) clears:
  - valid, rd, reg_write, wb_sel, result and pc_plus4 registers;
  - ld_hold;
  - FSM to RUN;
  - retire_count.
  All outputs read 0 during reset.
- Register update on each rising edge, in priority order:
  - stall=1: hold all registers (stall wins; flush is ignored that cycle).
  - else flush=1: valid<=0 and the other fields load normally (don't-care).
  - else: load all *_in fields, valid<=in_valid.
- wb_sel encoding:
  - 00: result
  - 01: load data
  - 10: pc_plus4
  - 11: reserved, behaves as 00
- Load data source is read_data_in in RUN and ld_hold in HOLD.
- Hold FSM, states RUN and HOLD:
  - RUN→HOLD when stall=1, valid=1 and wb_sel=01. Capture ld_hold<=read_data_in on that edge.
  - HOLD→RUN when stall=0; that cycle commits using ld_hold.
  - HOLD otherwise stays and ld_hold is frozen.
- commit = valid && !stall. Latency: an instruction accepted at edge N commits in cycle N+1 if not stalled.
- rf_we = commit && reg_write && (rd != 0). Writes to x0 are always suppressed.
- fwd_valid = valid && reg_write && (rd != 0). This is asserted during stall so that stalled consumers forward the correct value.
- retire_count increments by 1 on each commit edge, regardless of reg_write, and wraps modulo 2^CNT_WIDTH.
- Bubbles (valid=0) never write, forward or count.
- Reset mid-HOLD returns to RUN and discards ld_hold.

Decomposition:
- Shared package holds:
  - WB_SEL_ALU=2'b00, WB_SEL_MEM=2'b01, WB_SEL_PC4=2'b10 (shared with decode);
  - FSM state encoding ST_RUN, ST_HOLD.
- One natural sub-module: wb_retire_counter. It has a CNT_WIDTH parameter, clk, async active-low rst, an inc input and a count output.

Test Plan:
- ALU op, rd=5, result_in=0x0000_1234, wb_sel=00, valid=1 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, retire_count 0→1.
- Load, rd=7, wb_sel=01, read_data_in=0xFFFF_FF80 in WB cycle → rf_wdata=0xFFFF_FF80, rf_we=1.
- Load enters WB, stall=1 for 3 cycles, read_data_in changes 0xAAAA_0001→0x0 after the first stalled cycle:
  - rf_we=0 for 3 cycles;
  - fwd_data stays 0xAAAA_0001;
  - on release, write 0xAAAA_0001 and count once.
- jal, rd=1, pc_plus4_in=0x0000_0104, wb_sel=10 → rf_wdata=0x104. Same instruction with rd=0 → rf_we=0, fwd_valid=0, count still increments.
- flush=1 with in_valid=1 → next cycle valid=0, rf_we=0, count unchanged. flush=1 and stall=1 together → WB contents held unchanged.
- CNT_WIDTH=4, 17 consecutive commits → retire_count=1 (wrap). Assert rst=0 asynchronously mid-HOLD → outputs 0 immediately, FSM=RUN.
